// File: rtl/scanline_fx.sv
// -----------------------------------------------------------------------------
// scanline_fx
//
// CRT-style scanline darkening for a 24-bit RGB video stream. Every other
// active line (selected by phase) is scaled by 3/4, 2/4 or 1/4 depending on
// mode. Mode and phase are sampled only at the start of a frame (rising edge
// of VS) so a frame is never rendered with mixed settings. Fixed latency of
// two pixel clocks for RGB and all syncs.
//
// Parameters
//   BLANK_ZERO  1: RGB forced to zero while delayed DE is low
//               0: blanking-period RGB passed through untouched
//   LINE_W      width of the active-line counter (saturating)
//
// Ports
//   clk_vid      in   pixel clock, all state on rising edge
//   reset_n      in   asynchronous active-low reset
//   vid_rgb_in   in   {R,G,B} pixel, 8 bits per channel
//   vid_de_in    in   data enable (active pixels)
//   vid_hs_in    in   horizontal sync (passed through only)
//   vid_vs_in    in   vertical sync, rising edge = frame boundary
//   mode         in   0 off, 1 dim 25%, 2 dim 50%, 3 dim 75%
//   phase        in   0 dims odd active lines, 1 dims even active lines
//   vid_rgb_out  out  processed pixel, 2 cycles after input
//   vid_de_out   out  DE delayed by 2 cycles
//   vid_hs_out   out  HS delayed by 2 cycles
//   vid_vs_out   out  VS delayed by 2 cycles
//   line_cnt     out  index of the current active line (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module scanline_fx #(
  parameter int BLANK_ZERO = 1,
  parameter int LINE_W     = 11
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic [23:0]       vid_rgb_in,
  input  logic              vid_de_in,
  input  logic              vid_hs_in,
  input  logic              vid_vs_in,
  input  logic [1:0]        mode,
  input  logic              phase,
  output logic [23:0]       vid_rgb_out,
  output logic              vid_de_out,
  output logic              vid_hs_out,
  output logic              vid_vs_out,
  output logic [LINE_W-1:0] line_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Stage 1: raw pixel, syncs and the per-pixel weight decision.
  logic [23:0]       r_rgb_d1;
  logic              r_de_d1;
  logic              r_hs_d1;
  logic              r_vs_d1;
  logic [2:0]        r_w_d1;

  // Stage 2: weighted pixel and syncs, drive the outputs directly.
  logic [23:0]       r_rgb_d2;
  logic              r_de_d2;
  logic              r_hs_d2;
  logic              r_vs_d2;

  // Frame-level control.
  logic [1:0]        r_mode_l;
  logic              r_phase_l;
  logic [LINE_W-1:0] r_line_cnt;

  // ---------------------------------------------------------------------------
  // Edge detection and dim decision
  // ---------------------------------------------------------------------------
  logic              w_de_fall;
  logic              w_vs_rise;
  logic              w_cnt_max;
  logic              w_dim;
  logic [2:0]        w_weight;
  logic [23:0]       w_scaled;
  logic [23:0]       w_rgb_next;

  // Edges are taken between the live input and its stage-1 copy, so the
  // counter and the mode latch react on the same clock that captures the
  // first pixel after the edge.
  assign w_de_fall = r_de_d1 & ~vid_de_in;
  assign w_vs_rise = ~r_vs_d1 & vid_vs_in;
  assign w_cnt_max = &r_line_cnt;

  // The dim decision uses the settings and line index in force when the
  // pixel enters, i.e. the values that describe the line it belongs to.
  assign w_dim = (r_mode_l != 2'd0) && (r_line_cnt[0] != r_phase_l);

  // Weight in quarters: 4 = unity, 3/2/1 = 75/50/25 percent brightness.
  always_comb begin
    w_weight = 3'd4;
    if (w_dim) begin
      case (r_mode_l)
        2'd1:    w_weight = 3'd3;
        2'd2:    w_weight = 3'd2;
        2'd3:    w_weight = 3'd1;
        default: w_weight = 3'd4;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel weighting: c * w fits in 10 bits (255 * 4 = 1020), and the
  // >> 2 brings it back to 8 bits with plain truncation.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [9:0] w_prod;
      assign w_prod = {2'b00, r_rgb_d1[gi*8 +: 8]} * {7'd0, r_w_d1};
      assign w_scaled[gi*8 +: 8] = 8'(w_prod >> 2);
    end
  endgenerate

  // Outside active video the pixel is either blanked or left completely
  // untouched; the scanline effect only ever applies to active pixels.
  always_comb begin
    w_rgb_next = w_scaled;
    if (!r_de_d1) begin
      w_rgb_next = (BLANK_ZERO != 0) ? 24'h000000 : r_rgb_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb_d1 <= 24'h000000;
      r_de_d1  <= 1'b0;
      r_hs_d1  <= 1'b0;
      r_vs_d1  <= 1'b0;
      r_w_d1   <= 3'd0;
    end else begin
      r_rgb_d1 <= vid_rgb_in;
      r_de_d1  <= vid_de_in;
      r_hs_d1  <= vid_hs_in;
      r_vs_d1  <= vid_vs_in;
      r_w_d1   <= w_weight;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb_d2 <= 24'h000000;
      r_de_d2  <= 1'b0;
      r_hs_d2  <= 1'b0;
      r_vs_d2  <= 1'b0;
    end else begin
      r_rgb_d2 <= w_rgb_next;
      r_de_d2  <= r_de_d1;
      r_hs_d2  <= r_hs_d1;
      r_vs_d2  <= r_vs_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame control: settings latch and active-line counter
  // ---------------------------------------------------------------------------
  // After reset the latched mode is 0, so video passes through unmodified
  // until the first frame boundary supplies real settings.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_l  <= 2'd0;
      r_phase_l <= 1'b0;
    end else if (w_vs_rise) begin
      r_mode_l  <= mode;
      r_phase_l <= phase;
    end
  end

  // Frame clear has priority over a coincident end-of-line; the counter
  // sticks at all-ones if VS never arrives rather than wrapping and
  // flipping the dim parity.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_line_cnt <= '0;
    end else if (w_vs_rise) begin
      r_line_cnt <= '0;
    end else if (w_de_fall && !w_cnt_max) begin
      r_line_cnt <= r_line_cnt + {{(LINE_W-1){1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vid_rgb_out = r_rgb_d2;
  assign vid_de_out  = r_de_d2;
  assign vid_hs_out  = r_hs_d2;
  assign vid_vs_out  = r_vs_d2;
  assign line_cnt    = r_line_cnt;

endmodule

// File: doc/scanline_fx.md
SCANLINE_FX -- requirements
Module: scanline_fx

Interface
REQ-001 Parameter BLANK_ZERO, default 1; 1 forces the RGB output to zero whenever the delayed DE is low, 0 passes blanking-period RGB through unmodified.
REQ-002 Parameter LINE_W, default 11; width of the active-line counter.
REQ-003 clk_vid  input  1  pixel clock; all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 vid_rgb_in  input  24  pixel {R[23:16], G[15:8], B[7:0]}, the output of the upstream colour-deficiency stage.
REQ-006 vid_de_in  input  1  data enable, high during active pixels.
REQ-007 vid_hs_in  input  1  horizontal sync, passed through.
REQ-008 vid_vs_in  input  1  vertical sync; the rising edge marks the frame boundary.
REQ-009 mode  input  2  scanline strength: 0 off, 1 dim 25%, 2 dim 50%, 3 dim 75%.
REQ-010 phase  input  1  0 dims odd active lines, 1 dims even active lines.
REQ-011 vid_rgb_out  output  24  processed pixel.
REQ-012 vid_de_out / vid_hs_out / vid_vs_out  output  1 each  syncs delayed to match vid_rgb_out.
REQ-013 line_cnt  output  LINE_W  index of the current active line within the frame, for debug.

Function
REQ-014 Latency SHALL be exactly 2 clk_vid cycles from any input to the matching output, for RGB and all three syncs alike.
REQ-015 Stage 1 SHALL register rgb, de, hs and vs, and compute the dim flag for that pixel.
REQ-016 Stage 2 SHALL register the weighted RGB and the delayed syncs.
REQ-017 Edge detection SHALL use stage-1 registered copies: de_fall = de_d1 & ~de_in, and vs_rise = ~vs_d1 & vs_in.
REQ-018 mode_l and phase_l SHALL be latched from mode and phase only on vs_rise; mid-frame changes to mode or phase SHALL have no effect until the next vs_rise.
REQ-019 line_cnt SHALL clear to 0 on vs_rise.
REQ-020 line_cnt SHALL increment by 1 on de_fall.
REQ-021 line_cnt SHALL saturate at 2^LINE_W-1 and never wrap.
REQ-022 On a cycle where vs_rise and de_fall occur together, the clear SHALL win.
REQ-023 A pixel SHALL be dimmed iff mode_l != 0 and line_cnt[0] != phase_l.
REQ-024 Weight w SHALL be 4 if the pixel is not dimmed, and otherwise 3, 2 or 1 for mode_l = 1, 2 or 3.
REQ-025 Each channel SHALL be computed as out = (c * w) >> 2, using a 10-bit intermediate that is then truncated to 8 bits; no rounding and no overflow is possible.
REQ-026 With mode_l = 0, vid_rgb_out SHALL equal vid_rgb_in delayed by 2 cycles, bit-exact.
REQ-027 With BLANK_ZERO = 1, vid_rgb_out SHALL be 24'h000000 whenever vid_de_out = 0.
REQ-028 hs SHALL NOT affect line counting; only DE edges define lines.
REQ-029 A frame with no vs_rise SHALL keep counting lines until saturation.

Reset
REQ-030 While reset_n = 0, all pipeline registers, vid_rgb_out, vid_de_out, vid_hs_out, vid_vs_out, line_cnt, mode_l and phase_l SHALL be 0, asynchronously.
REQ-031 After reset release, mode_l SHALL remain 0 (passthrough) until the first vs_rise.
REQ-032 Reset asserted mid-line SHALL drop all outputs to 0 in the same instant, with no partial pixel emitted afterwards.
REQ-033 Deassertion SHALL be sampled synchronously on clk_vid; the first valid outputs SHALL appear 2 cycles after the first post-reset input.

Verification
REQ-034 Passthrough: mode=0, phase=0, a frame of 4 lines x 8 pixels of rgb 24'hFF8040 -> output 24'hFF8040 on every active pixel, DE/HS/VS exactly 2 cycles late, line_cnt counting 0..4.
REQ-035 Dim 50%: mode=2 latched at vs_rise, phase=0, input 24'hFF8040 -> lines 0 and 2 output 24'hFF8040, lines 1 and 3 output 24'h7F4020.
REQ-036 Dim 75% with phase=1: mode=3, input 24'hFFFFFF -> lines 0 and 2 output 24'h3F3F3F, lines 1 and 3 output 24'hFFFFFF; mode=1 on the same stimulus -> dimmed lines output 24'hBFBFBF.
REQ-037 Mid-frame mode change: mode switched 0->2 during line 1 -> the rest of the frame is unchanged (passthrough); the next frame's line 1 outputs 24'h7F4020 for input 24'hFF8040.
REQ-038 Boundaries: vs_rise coincident with de_fall -> line_cnt = 0 the next cycle; 2100 lines with no VS at LINE_W=11 -> line_cnt holds at 2047; blanking with rgb 24'h123456 -> output 24'h000000 when BLANK_ZERO=1, 24'h123456 when BLANK_ZERO=0.
REQ-039 Reset mid-operation: reset_n pulsed low for 3 cycles during an active line with mode_l=3 -> all outputs read 0 immediately; after release, passthrough holds until the next vs_rise.
